alu_result_regfile: RTL and testbench
=====================================

// Module: alu_result_regfile
// PURPOSE
// - Parametrised successor to the 2-bit ALU result register: DEPTH entries of WIDTH bits plus an ALU flag register.
// - Sits after the ALU and captures results (data + NZCV flags) for the 7-segment/LED display path.
// - Two operating modes:
//   - ADDR: the write goes to waddr.
//   - RING: the write goes to an internal pointer that auto-increments, and the block keeps a fill count.
// - Two combinational read ports with write-through bypass.
// PARAMETERS
// - WIDTH  4  data bits per entry (>=1)
// - DEPTH  4  number of entries (>=2; need not be a power of 2)
// - AW     $clog2(DEPTH)  localparam, address width
// PORTS
// - clk       in   1        clock; all state changes on posedge
// - rst       in   1        reset, asynchronous, active-high
// - clr       in   1        synchronous clear of all state
// - we        in   1        write enable
// - mode      in   1        alu_pkg::mode_e: 0=MODE_ADDR, 1=MODE_RING
// - waddr     in   AW       write address (MODE_ADDR only)
// - wdata     in   WIDTH    ALU result to store
// - wflags    in   4        alu_pkg::flags_t {N,Z,C,V} from ALU
// - raddr_a   in   AW       read address, port A
// - rdata_a   out  WIDTH    read data, port A
// - raddr_b   in   AW       read address, port B
// - rdata_b   out  WIDTH    read data, port B
// - flags_q   out  4        flags of the last accepted write
// - wptr      out  AW       ring write pointer
// - count     out  AW+1     valid entries written in ring mode, 0..DEPTH
// - full      out  1        count == DEPTH
// BEHAVIOUR
// - Reset (rst=1, async): all entries=0, flags_q=0, wptr=0, count=0, full=0; held while rst=1.
// - Priority each posedge: rst > clr > we. clr=1 gives the same state as reset one cycle later; a concurrent we is dropped.
// - Effective write address (ea): MODE_ADDR -> waddr; MODE_RING -> wptr.
// - Write (we=1, clr=0):
//   - mem[ea] <= wdata and flags_q <= wflags; write latency 1 cycle.
//   - MODE_ADDR with waddr >= DEPTH: write ignored, flags_q unchanged, no pointer or count change.
//   - MODE_RING: wptr <= (wptr==DEPTH-1) ? 0 : wptr+1; count <= min(count+1, DEPTH).
//   - Ring wrap while full: overwrite the oldest entry; count stays DEPTH.
// - MODE_ADDR writes never move wptr or count. mode may change any cycle; the ring resumes from the held wptr.
// - Reads are combinational, 0-cycle latency:
//   - raddr >= DEPTH -> rdata = 0.
//   - Bypass: if we=1, clr=0, rst=0, the write is valid and raddr==ea, rdata=wdata in the same cycle.
//   - Both ports may read the same address; both may bypass at once.
// - flags_q has no bypass; it reflects the last committed write only.
// - full is combinational from count; never glitches across reset.
// - No X on outputs after reset for any input sequence; width rules are unsigned, with no truncation of count.
// STRUCTURE
// - Package alu_pkg:
//   - typedef struct packed {logic n,z,c,v;} flags_t
//   - typedef enum logic {MODE_ADDR, MODE_RING} mode_e
//   - localparam FLAGS_W=4
// - Sub-module regfile_entry #(WIDTH): one register with async rst, sync clr, en; instantiated DEPTH times via generate.
// - Top holds write decode, wptr/count logic, flags register, and read/bypass muxes.
// TESTING
// - Reset: drive rst=1 mid-stream after 3 ring writes -> all rdata=0, flags_q=0, wptr=0, count=0 immediately, before the next edge.
// - ADDR mode, WIDTH=4 DEPTH=4: write 0xA@2 flags 4'b1000, then read A=2 -> 0xA, flags_q=1000; also write @1 with raddr_b=1 -> same-cycle rdata_b=wdata.
// - RING wrap: 5 writes 1..5 -> wptr=1, count=4, full=1, mem={5,2,3,4}.
// - Priority: clr=1 with we=1 wdata=0xF -> next cycle all entries 0, count=0, flags_q=0.
// - DEPTH=3 instance: ADDR write to waddr=3 -> ignored, flags_q unchanged; raddr_a=3 -> 0; ring pointer wraps 2->0.
// - Mode switch: 2 ring writes (wptr=2), ADDR write @0, ring write -> lands at 2, wptr=3, count=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result register file.
//   flags_t : packed {N,Z,C,V} flag bundle produced by the ALU
//   mode_e  : write addressing mode (direct address or ring pointer)
//   FLAGS_W : width of flags_t
package alu_pkg;

  localparam int unsigned FLAGS_W = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RING = 1'b1
  } mode_e;

endpackage

// File: rtl/alu_result_regfile_if.sv
// Bus between the ALU side and the result register file.
//   master : drives clr/we/mode/waddr/wdata/wflags and both read addresses,
//            observes read data, committed flags, ring pointer, count, full
//   slave  : the register file itself
interface alu_result_regfile_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic             clr;
  logic             we;
  mode_e            mode;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  flags_t           wflags;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  flags_t           flags_q;
  logic [AW-1:0]    wptr;
  logic [AW:0]      count;
  logic             full;

  modport master (
    output clr, we, mode, waddr, wdata, wflags, raddr_a, raddr_b,
    input  rdata_a, rdata_b, flags_q, wptr, count, full
  );

  modport slave (
    input  clr, we, mode, waddr, wdata, wflags, raddr_a, raddr_b,
    output rdata_a, rdata_b, flags_q, wptr, count, full
  );

endinterface

// File: rtl/regfile_entry.sv
// One register-file entry.
//   clk_i, rst_i (async, active-high), clr_i (sync clear), en_i (load d_i),
//   d_i / q_o : entry data in / out
module regfile_entry #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_result_regfile.sv
// ALU result register file: DEPTH entries of WIDTH bits plus a flag register.
//   clk, rst (async, active-high)
//   bus (slave) : write port (direct address or auto-incrementing ring pointer),
//                 two combinational read ports with write-through bypass,
//                 committed flags, ring pointer, ring fill count and full
module alu_result_regfile
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  alu_result_regfile_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ea;
  logic             wr_en;
  logic             byp_en;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  flags_t           flags_reg_q, flags_d;

  assign ea    = (bus.mode == MODE_RING) ? wptr_q : bus.waddr;
  // Out-of-range direct addresses are dropped entirely; wptr is always in range.
  assign wr_en = bus.we && !bus.clr && ({1'b0, ea} < CW'(DEPTH));
  // Bypass must not leak wdata while reset holds the outputs at zero.
  assign byp_en = wr_en && !rst;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    regfile_entry #(
      .WIDTH(WIDTH)
    ) u_entry (
      .clk_i(clk),
      .rst_i(rst),
      .clr_i(bus.clr),
      .en_i (wr_en && (ea == AW'(i))),
      .d_i  (bus.wdata),
      .q_o  (mem[i])
    );
  end

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    flags_d = flags_reg_q;
    if (bus.clr) begin
      wptr_d  = '0;
      count_d = '0;
      flags_d = '0;
    end else if (wr_en) begin
      flags_d = bus.wflags;
      if (bus.mode == MODE_RING) begin
        wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        // Saturates at DEPTH: wrapping while full overwrites the oldest entry.
        if (count_q != CW'(DEPTH)) begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      count_q     <= '0;
      flags_reg_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      flags_reg_q <= flags_d;
    end
  end

  always_comb begin
    bus.rdata_a = '0;
    bus.rdata_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == AW'(i)) bus.rdata_a = mem[i];
      if (bus.raddr_b == AW'(i)) bus.rdata_b = mem[i];
    end
    if (byp_en && (bus.raddr_a == ea)) bus.rdata_a = bus.wdata;
    if (byp_en && (bus.raddr_b == ea)) bus.rdata_b = bus.wdata;
  end

  assign bus.flags_q = flags_reg_q;
  assign bus.wptr    = wptr_q;
  assign bus.count   = count_q;
  assign bus.full    = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_alu_result_regfile.sv
// Self-checking bench for alu_result_regfile: a DEPTH=4 instance driven with
// a scoreboard of committed writes, and a DEPTH=3 instance for range/wrap cases.
module tb_alu_result_regfile;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_regfile_if #(.WIDTH(4), .DEPTH(4)) bus4 ();
  alu_result_regfile_if #(.WIDTH(4), .DEPTH(3)) bus3 ();

  alu_result_regfile #(.WIDTH(4), .DEPTH(4)) u_dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4.slave)
  );

  alu_result_regfile #(.WIDTH(4), .DEPTH(3)) u_dut3 (
    .clk(clk),
    .rst(rst),
    .bus(bus3.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state for the DEPTH=4 instance.
  logic [3:0] m4 [4];
  int         wptr4;
  int         cnt4;
  logic [3:0] flags4;

  typedef struct {
    int         addr;
    logic [3:0] data;
  } exp_t;
  exp_t sb4[$];

  task automatic model_clear4();
    for (int i = 0; i < 4; i++) m4[i] = 4'h0;
    wptr4  = 0;
    cnt4   = 0;
    flags4 = 4'h0;
  endtask

  task automatic check_state4(input string tag);
    check({tag, "_flags"}, 32'(bus4.flags_q), 32'(flags4));
    check({tag, "_wptr"},  32'(bus4.wptr),    32'(wptr4));
    check({tag, "_count"}, 32'(bus4.count),   32'(cnt4));
    check({tag, "_full"},  32'(bus4.full),    32'(cnt4 == 4));
  endtask

  task automatic check_mem4(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus4.raddr_a = 2'(i);
      #1;
      check({tag, "_mem"}, 32'(bus4.rdata_a), 32'(m4[i]));
    end
  endtask

  task automatic drain4();
    exp_t e;
    while (sb4.size() > 0) begin
      e = sb4.pop_front();
      bus4.raddr_a = 2'(e.addr);
      #1;
      check("readback_a", 32'(bus4.rdata_a), 32'(e.data));
    end
  endtask

  task automatic wr4(input mode_e m, input int addr, input logic [3:0] d, input logic [3:0] f);
    int ea;
    @(negedge clk);
    ea = (m == MODE_RING) ? wptr4 : addr;
    bus4.we      = 1'b1;
    bus4.mode    = m;
    bus4.waddr   = 2'(addr);
    bus4.wdata   = d;
    bus4.wflags  = f;
    bus4.raddr_b = 2'(ea);
    #1;
    check("bypass_b", 32'(bus4.rdata_b), 32'(d));
    @(posedge clk);
    #1;
    bus4.we = 1'b0;
    m4[ea]  = d;
    flags4  = f;
    if (m == MODE_RING) begin
      wptr4 = (wptr4 == 3) ? 0 : wptr4 + 1;
      if (cnt4 < 4) cnt4++;
    end
    sb4.push_back('{addr: ea, data: d});
    drain4();
    check_state4("wr");
  endtask

  task automatic clr4();
    @(negedge clk);
    bus4.clr   = 1'b1;
    bus4.we    = 1'b1;
    bus4.mode  = MODE_RING;
    bus4.wdata = 4'hF;
    bus4.wflags = 4'hF;
    @(posedge clk);
    #1;
    bus4.clr = 1'b0;
    bus4.we  = 1'b0;
    model_clear4();
    check_state4("clr");
    check_mem4("clr");
  endtask

  initial begin
    rst = 1'b1;
    bus4.clr = 1'b0; bus4.we = 1'b0; bus4.mode = MODE_ADDR; bus4.waddr = '0;
    bus4.wdata = '0; bus4.wflags = '0; bus4.raddr_a = '0; bus4.raddr_b = '0;
    bus3.clr = 1'b0; bus3.we = 1'b0; bus3.mode = MODE_ADDR; bus3.waddr = '0;
    bus3.wdata = '0; bus3.wflags = '0; bus3.raddr_a = '0; bus3.raddr_b = '0;
    model_clear4();
    #1;
    check_state4("reset");
    check("reset_rdata_b", 32'(bus4.rdata_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Direct-address writes, including same-cycle bypass on port B.
    wr4(MODE_ADDR, 2, 4'hA, 4'b1000);
    check("addr_flags_const", 32'(bus4.flags_q), 32'b1000);
    wr4(MODE_ADDR, 1, 4'h6, 4'b0100);
    bus4.raddr_a = 2'd2;
    #1;
    check("addr_a2_const", 32'(bus4.rdata_a), 32'hA);

    // Clear beats a concurrent write.
    clr4();

    // Ring wrap: five writes into four entries.
    for (int i = 1; i <= 5; i++) wr4(MODE_RING, 0, 4'(i), 4'(i));
    check("wrap_wptr", 32'(bus4.wptr), 32'd1);
    check("wrap_count", 32'(bus4.count), 32'd4);
    check("wrap_full", 32'(bus4.full), 32'd1);
    check_mem4("wrap");

    // Mode switch: ring resumes from held pointer.
    clr4();
    wr4(MODE_RING, 0, 4'h1, 4'h1);
    wr4(MODE_RING, 0, 4'h2, 4'h2);
    wr4(MODE_ADDR, 0, 4'h7, 4'h3);
    wr4(MODE_RING, 0, 4'h9, 4'h4);
    check("switch_wptr", 32'(bus4.wptr), 32'd3);
    check("switch_count", 32'(bus4.count), 32'd3);
    bus4.raddr_a = 2'd2;
    #1;
    check("switch_mem2", 32'(bus4.rdata_a), 32'h9);

    // Asynchronous reset mid-stream; bypass suppressed while rst is high.
    clr4();
    for (int i = 0; i < 3; i++) wr4(MODE_RING, 0, 4'(i + 3), 4'hE);
    @(negedge clk);
    rst          = 1'b1;
    bus4.we      = 1'b1;
    bus4.mode    = MODE_ADDR;
    bus4.waddr   = 2'd0;
    bus4.wdata   = 4'hF;
    bus4.raddr_b = 2'd0;
    model_clear4();
    #1;
    check("rst_bypass_b", 32'(bus4.rdata_b), 32'h0);
    check_state4("rst_async");
    check_mem4("rst_async");
    @(negedge clk);
    bus4.we = 1'b0;
    rst     = 1'b0;

    // DEPTH=3: out-of-range write dropped, out-of-range read is zero.
    @(negedge clk);
    bus3.we = 1'b1; bus3.mode = MODE_ADDR; bus3.waddr = 2'd0;
    bus3.wdata = 4'h3; bus3.wflags = 4'b0010;
    @(posedge clk);
    #1;
    bus3.we = 1'b0;
    check("d3_flags_valid", 32'(bus3.flags_q), 32'b0010);
    @(negedge clk);
    bus3.we = 1'b1; bus3.waddr = 2'd3; bus3.wdata = 4'h5; bus3.wflags = 4'b1111;
    bus3.raddr_a = 2'd3;
    #1;
    check("d3_oor_read", 32'(bus3.rdata_a), 32'h0);
    @(posedge clk);
    #1;
    bus3.we = 1'b0;
    check("d3_oor_flags", 32'(bus3.flags_q), 32'b0010);
    check("d3_oor_read_after", 32'(bus3.rdata_a), 32'h0);
    check("d3_oor_count", 32'(bus3.count), 32'd0);
    bus3.raddr_b = 2'd0;
    #1;
    check("d3_mem0", 32'(bus3.rdata_b), 32'h3);

    // DEPTH=3 ring: pointer goes 1, 2, 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus3.we = 1'b1; bus3.mode = MODE_RING; bus3.wdata = 4'(i + 8);
      @(posedge clk);
      #1;
      bus3.we = 1'b0;
      check("d3_ring_wptr", 32'(bus3.wptr), 32'((i + 1) % 3));
    end
    check("d3_ring_count", 32'(bus3.count), 32'd3);
    check("d3_ring_full", 32'(bus3.full), 32'd1);
    bus3.raddr_a = 2'd0;
    #1;
    check("d3_ring_mem0", 32'(bus3.rdata_a), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
